fir_mac_filter: RTL and testbench

- Parametrised, multi-channel FIR filter for the audio path. Sits between the ADC sample synchroniser and the LED/level logic.
- Uses one time-multiplexed multiply-accumulate unit instead of one multiplier per tap.
- Coefficients are run-time loadable, each channel keeps its own sample history, and the output is rounded, saturated and optionally offset-binary, delivered with a valid strobe.

---
 rtl/fir_mac_filter.sv | 153 +++++++++++++++
 tb/tb_fir_mac_filter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_filter.sv
// Multi-channel FIR filter built around one time-multiplexed MAC. Coefficients are loadable at run time.
// Each channel has its own circular sample history. The result is rounded, saturated and optionally offset-binary.
module fir_mac_filter #(
   parameter int DATA_W     = 12,
   parameter int COEF_W     = 16,
   parameter int TAPS       = 51,
   parameter int CHANNELS   = 2,
   parameter int FRAC_BITS  = 15,
   parameter int ACC_W      = 36,
   parameter int OUT_OFFSET = 1,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int TAP_W     = $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CH_W-1:0]   in_chan,
   input  logic              coef_we,
   input  logic [TAP_W-1:0]  coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic              coef_err,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_chan,
   output logic              out_sat
);

   localparam int HIST_N = CHANNELS * TAPS;
   localparam int HW     = (HIST_N > 1) ? $clog2(HIST_N) : 1;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
   localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;
   localparam logic [DATA_W-1:0] OFF_MASK = (OUT_OFFSET != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
   localparam logic [CH_W:0]     CH_LIM   = (CH_W + 1)'(CHANNELS);
   localparam logic [TAP_W:0]    TAP_LIM  = (TAP_W + 1)'(TAPS);

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

   state_t                    state, state_nx;
   logic [HW-1:0]             clr_idx;
   logic [TAP_W-1:0]          k;
   logic [CH_W-1:0]           chan_q;
   logic [TAP_W-1:0]          wptr [CHANNELS];
   logic signed [COEF_W-1:0]  coef [TAPS];
   logic signed [DATA_W-1:0]  hist [HIST_N];
   logic signed [ACC_W-1:0]   acc_p0;
   logic [DATA_W-1:0]         res_p1;
   logic                      sat_p1;

   logic                      chan_ok, coef_ok, accept;
   logic [TAP_W-1:0]          in_ptr, ptr_adv, mac_ptr;
   int                        rd_tap;
   logic [HW-1:0]             rd_idx, wr_idx;
   logic signed [PROD_W-1:0]  prod;
   logic [DATA_W:0]           rounded;

   function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
      return (a + RND_HALF) >>> FRAC_BITS;
   endfunction

   // Returns {clipped, value}.
   function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] r);
      if (r > SAT_HI) return {1'b1, SAT_HI[DATA_W-1:0]};
      if (r < SAT_LO) return {1'b1, SAT_LO[DATA_W-1:0]};
      return {1'b0, r[DATA_W-1:0]};
   endfunction

   assign chan_ok = ({1'b0, in_chan} < CH_LIM);
   assign coef_ok = ({1'b0, coef_addr} < TAP_LIM);
   assign accept  = (state == S_IDLE) && in_valid && chan_ok;
   assign in_ptr  = wptr[in_chan];
   assign ptr_adv = (in_ptr == TAP_W'(TAPS - 1)) ? '0 : in_ptr + 1'b1;
   assign mac_ptr = wptr[chan_q];

   // Tap k reads the sample k positions behind the newest one, modulo TAPS.
   always_comb begin
      rd_tap = (k > mac_ptr) ? int'(mac_ptr) + TAPS - int'(k) : int'(mac_ptr) - int'(k);
      rd_idx = HW'(int'(chan_q) * TAPS + rd_tap);
      wr_idx = HW'(int'(in_chan) * TAPS + int'(ptr_adv));
   end

   assign prod    = coef[k] * hist[rd_idx];
   assign rounded = saturate(round_half_up(acc_p0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_CLEAR;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         S_CLEAR: if (clr_idx == HW'(HIST_N - 1)) state_nx = S_IDLE;
         S_IDLE: begin
            in_ready = 1'b1;
            if (accept) state_nx = S_MAC;
         end
         S_MAC:   if (k == TAP_W'(TAPS - 1)) state_nx = S_ROUND;
         S_ROUND: state_nx = S_OUT;
         S_OUT:   state_nx = S_IDLE;
         default: state_nx = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_idx   <= '0;
         k         <= '0;
         chan_q    <= '0;
         coef_err  <= 1'b0;
         out_valid <= 1'b0;
         out_sat   <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         for (int c = 0; c < CHANNELS; c++) wptr[c] <= '0;
         for (int t = 0; t < TAPS; t++) coef[t] <= '0;
      end else begin
         out_valid <= (state == S_OUT);
         coef_err  <= coef_we && coef_ok && (state != S_IDLE);
         if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
         if ((state == S_IDLE) && coef_we && coef_ok) coef[coef_addr] <= coef_data;
         if (accept) begin
            wptr[in_chan] <= ptr_adv;
            chan_q        <= in_chan;
            k             <= '0;
         end else if (state == S_MAC) begin
            k <= k + 1'b1;
         end
         if (state == S_OUT) begin
            out_data <= res_p1;
            out_sat  <= sat_p1;
            out_chan <= chan_q;
         end
      end
   end

   // p0: history write and accumulate; p1: rounded/saturated result awaiting OUT
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) hist[clr_idx] <= '0;
      else if (accept)      hist[wr_idx]  <= in_data;
      if (accept)               acc_p0 <= '0;
      else if (state == S_MAC)  acc_p0 <= acc_p0 + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      if (state == S_ROUND) begin
         sat_p1 <= rounded[DATA_W];
         res_p1 <= rounded[DATA_W-1:0] ^ OFF_MASK;
      end
   end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed bench for fir_mac_filter with default parameters (51 taps, 2 channels, offset-binary output).
module tb_fir_mac_filter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_data = '0;
   logic [0:0]  in_chan = '0;
   logic        coef_we = 1'b0;
   logic [5:0]  coef_addr = '0;
   logic [15:0] coef_data = '0;
   logic        coef_err;
   logic        out_valid;
   logic [11:0] out_data;
   logic [0:0]  out_chan;
   logic        out_sat;

   int n_tests = 0;
   int n_fail  = 0;

   fir_mac_filter dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_chan(in_chan), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
      .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("ready_timeout", 0, 1);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_ready();
   endtask

   task automatic load_coef(input int addr, input int val);
      wait_ready();
      coef_we   = 1'b1;
      coef_addr = 6'(addr);
      coef_data = 16'(val);
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic start(input int chan, input int data);
      wait_ready();
      in_chan  = 1'(chan);
      in_data  = 12'(data);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Called on the first negedge after the accepting posedge; lat counts posedges until out_valid.
   task automatic wait_out(output int d, output int c, output int s, output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      d = int'(out_data);
      c = int'(out_chan);
      s = int'(out_sat);
   endtask

   task automatic send(input string tag, input int chan, input int data, input int exp_d, input int exp_s);
      int d, c, s, lat;
      start(chan, data);
      wait_out(d, c, s, lat);
      check({tag, ":data"}, d, exp_d);
      check({tag, ":chan"}, c, chan);
      check({tag, ":sat"}, s, exp_s);
      check({tag, ":latency"}, lat, 53);
   endtask

   initial begin
      int cnt, j, bad, seen, d, c, s, lat;

      // Reset values, then release with a sample already waiting
      rst = 1'b1; in_valid = 1'b1; in_data = 12'd100; in_chan = '0;
      repeat (3) @(negedge clk);
      check("rst:in_ready", int'(in_ready), 0);
      check("rst:out_valid", int'(out_valid), 0);
      check("rst:out_data", int'(out_data), 0);
      check("rst:out_sat", int'(out_sat), 0);
      check("rst:coef_err", int'(coef_err), 0);
      rst = 1'b0;
      cnt = 0;
      while (!in_ready && cnt < 400) begin
         cnt++;
         @(negedge clk);
      end
      check("clear_len", cnt, 102);
      @(negedge clk);
      in_valid = 1'b0;
      j = 103; bad = 0;
      while (!out_valid && j < 400) begin
         if (out_data != 0) bad++;
         @(negedge clk);
         j++;
      end
      check("rel:out_cycle", j, 156);
      check("rel:zero_before", bad, 0);
      check("rel:out_data", int'(out_data), 2048);

      // Impulse response through coef[0] and coef[3]
      do_reset();
      load_coef(0, 16384);
      load_coef(3, -8192);
      send("imp0", 0, 1000, 2548, 0);
      send("imp1", 0, 0, 2048, 0);
      send("imp2", 0, 0, 2048, 0);
      send("imp3", 0, 0, 1798, 0);
      send("imp4", 0, 0, 2048, 0);

      // Independent channel histories
      do_reset();
      load_coef(0, 16384);
      load_coef(3, -8192);
      send("iso0_ch0", 0, 1000, 2548, 0);
      send("iso0_ch1", 1, -1000, 1548, 0);
      send("iso1_ch0", 0, 0, 2048, 0);
      send("iso1_ch1", 1, 0, 2048, 0);
      send("iso2_ch0", 0, 0, 2048, 0);
      send("iso2_ch1", 1, 0, 2048, 0);
      send("iso3_ch0", 0, 0, 1798, 0);
      send("iso3_ch1", 1, 0, 2298, 0);

      // Saturation at both rails, with the first sample just inside the range
      do_reset();
      for (int t = 0; t < 51; t++) load_coef(t, 32767);
      send("satp0", 0, 2047, 4095, 0);
      send("satp1", 0, 2047, 4095, 1);
      send("satp2", 0, 2047, 4095, 1);
      do_reset();
      for (int t = 0; t < 51; t++) load_coef(t, 32767);
      send("satn0", 0, -2048, 0, 0);
      send("satn1", 0, -2048, 0, 1);

      // Round half up
      do_reset();
      load_coef(0, 16384);
      send("rnd_half", 0, 1, 2049, 0);
      send("rnd_neg_half", 0, -1, 2048, 0);
      load_coef(0, 16383);
      send("rnd_below", 0, 1, 2048, 0);

      // Writes outside IDLE are dropped; writes during an accept take effect
      do_reset();
      load_coef(0, 16384);
      start(0, 1000);
      coef_we = 1'b1; coef_addr = 6'd0; coef_data = 16'd0;
      @(negedge clk);
      coef_we = 1'b0;
      check("drop:err_pulse", int'(coef_err), 1);
      coef_we = 1'b1; coef_addr = 6'd60;
      @(negedge clk);
      coef_we = 1'b0;
      check("drop:err_clear", int'(coef_err), 0);
      @(negedge clk);
      check("oor:no_err", int'(coef_err), 0);
      wait_out(d, c, s, lat);
      check("drop:data", d, 2548);
      send("drop_keep", 0, 1000, 2548, 0);
      wait_ready();
      coef_we = 1'b1; coef_addr = 6'd0; coef_data = 16'd8192;
      in_valid = 1'b1; in_chan = '0; in_data = 12'd1000;
      @(negedge clk);
      coef_we = 1'b0; in_valid = 1'b0;
      check("samecyc:no_err", int'(coef_err), 0);
      wait_out(d, c, s, lat);
      check("samecyc:data", d, 2298);

      // Reset in the middle of MAC
      do_reset();
      load_coef(0, 16384);
      start(0, 1000);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst:in_ready", int'(in_ready), 0);
      check("midrst:out_valid", int'(out_valid), 0);
      rst = 1'b0;
      cnt = 0; seen = 0;
      while (!in_ready && cnt < 400) begin
         cnt++;
         if (out_valid) seen++;
         @(negedge clk);
      end
      check("midrst:clear_len", cnt, 102);
      check("midrst:no_valid", seen, 0);
      send("midrst_coef0", 0, 1000, 2048, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
